// File: rtl/fetch_unit.sv
// Instruction fetch: pc register driving a combinational imem plus a DEPTH-entry {pc, inst} buffer to the decoder.
// Optional macro FETCH_MISALIGN_CHECK_EN aligns redirect targets and raises a sticky misalign flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        dec_ready,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        misalign
);

  localparam int             PW      = (DEPTH > 2) ? 2 : 1;
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_pc_q   [DEPTH];
  logic [31:0]   buf_inst_q [DEPTH];

  logic          pop;
  logic          push;
  logic [31:0]   target_eff;
  logic          target_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign target_eff = {redirect_target[31:2], 2'b00};
  assign target_bad = |redirect_target[1:0];
  assign misalign   = misalign_q;
`else
  assign target_eff = redirect_target;
  assign target_bad = 1'b0;
  assign misalign   = 1'b0;
`endif

  assign imem_addr = pc_q;
  assign dec_valid = (count_q != '0);
  assign dec_pc    = dec_valid ? buf_pc_q[rd_ptr_q]   : 32'h0;
  assign dec_inst  = dec_valid ? buf_inst_q[rd_ptr_q] : 32'h0;

  assign pop  = dec_valid && dec_ready;
  assign push = !redirect_valid && ((count_q != DEPTH_C) || pop);

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif
    if (redirect_valid) begin
      // Flush drops everything, including an entry the decoder takes this edge.
      pc_d     = target_eff;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d = misalign_q | target_bad;
`endif
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Storage needs no reset: outputs are masked by count.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      buf_pc_q[wr_ptr_q]   <= pc_q;
      buf_inst_q[wr_ptr_q] <= imem_data;
    end
  end

  // target_bad is only consumed when the misalign check is built in.
  logic unused_ok;
  assign unused_ok = target_bad;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit with a queue-based reference model and negedge monitor.
module tb_fetch_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        dec_ready;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        misalign;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .dec_ready(dec_ready), .dec_valid(dec_valid),
    .dec_inst(dec_inst), .dec_pc(dec_pc), .misalign(misalign)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]};
  endfunction

  assign imem_data = inst_of(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        mon_e;
  logic [31:0] m_pc;
  logic        m_mis;
  bit          started = 0;
  bit          m_pop, m_push;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a plain queue, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pc  = RESET_PC;
      m_mis = 1'b0;
      exp_q.delete();
      started = 1;
    end else if (started) begin
      m_pop = (exp_q.size() != 0) && dec_ready;
      if (redirect_valid) begin
        exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
        m_pc = {redirect_target[31:2], 2'b00};
        if (redirect_target[1:0] != 2'b00) m_mis = 1'b1;
`else
        m_pc = redirect_target;
`endif
      end else begin
        m_push = (exp_q.size() < DEPTH) || m_pop;
        if (m_pop) void'(exp_q.pop_front());
        if (m_push) begin
          exp_q.push_back('{pc: m_pc, inst: inst_of(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Monitor: compare what the DUT presents against the head of the expected queue.
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() != 0) mon_e = exp_q[0];
      else                   mon_e = '0;
      chk("dec_valid", {31'b0, dec_valid}, {31'b0, exp_q.size() != 0});
      chk("dec_pc",    dec_pc,    mon_e.pc);
      chk("dec_inst",  dec_inst,  mon_e.inst);
      chk("imem_addr", imem_addr, m_pc);
      chk("misalign",  {31'b0, misalign}, {31'b0, m_mis});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    step(1);
    redirect_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    dec_ready = 1'b0;
    step(2);
    rst = 1'b0;
    dec_ready = 1'b1;
    step(4);                          // streaming 0x0, 0x4, 0x8
    dec_ready = 1'b0;
    step(5);                          // buffer saturates
    dec_ready = 1'b1;
    step(4);
    dec_ready = 1'b0;
    step(3);
    redirect(32'h0000_0100);          // redirect while full
    step(3);
    dec_ready = 1'b1;
    step(3);
    redirect(32'hFFFF_FFFC);          // pc wrap
    step(4);
    redirect(32'h0000_0102);          // misaligned target
    step(4);
    redirect_valid = 1'b1;            // back-to-back redirects
    redirect_target = 32'h0000_0200;
    step(1);
    redirect_target = 32'h0000_0300;
    step(1);
    redirect_valid = 1'b0;
    step(3);
    dec_ready = 1'b0;
    step(3);
    rst = 1'b1;                       // reset overrides redirect with buffered entries
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0444;
    step(1);
    rst = 1'b0;
    redirect_valid = 1'b0;
    dec_ready = 1'b1;
    step(3);
    for (int i = 0; i < 2000; i++) begin
      dec_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 9) == 0);
      redirect_target = $urandom;
      if ($urandom_range(0, 1) == 0) redirect_target[1:0] = 2'b00;
      rst             = ($urandom_range(0, 79) == 0);
      step(1);
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, the fetch-buffer entry count; legal values 2 or 4.
REQ-003 The block SHALL run on one clock with synchronous active-high reset; every other port below is fixed by this interface.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_addr  output  32  byte address to instruction memory; combinational read, data valid in the same cycle.
REQ-007 imem_data  input  32  big-endian instruction word read at imem_addr.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_target  input  32  redirect byte address.
REQ-010 dec_ready  input  1  decoder can accept an instruction this cycle.
REQ-011 dec_valid  output  1  dec_inst/dec_pc hold a valid instruction.
REQ-012 dec_inst  output  32  instruction word at buffer head.
REQ-013 dec_pc  output  32  byte address of dec_inst.
REQ-014 misalign  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-015 The block SHALL hold a 32-bit pc register and drive imem_addr = pc combinationally at all times.
REQ-016 The block SHALL hold a DEPTH-entry FIFO of {pc, instruction} pairs with a count register.
REQ-017 Pop SHALL occur on a clock edge where dec_valid and dec_ready are both 1.
REQ-018 Push SHALL occur on a clock edge where redirect_valid is 0 and (count < DEPTH or a pop occurs that edge); the entry written is {pc, imem_data}, and pc SHALL advance to pc + 4.
REQ-019 When no push occurs and redirect_valid is 0, pc SHALL hold.
REQ-020 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-021 dec_valid SHALL equal (count != 0); dec_inst/dec_pc SHALL show the head entry, and SHALL be 0 when count is 0.
REQ-022 Simultaneous push and pop with count = DEPTH SHALL leave count unchanged and preserve order.
REQ-023 On redirect_valid = 1: FIFO SHALL flush (count <- 0), pc <- redirect target, no push that edge; a same-cycle pop still counts as accepted by the decoder.
REQ-024 Redirect SHALL have priority over push; back-to-back redirects SHALL each reload pc, last one wins.
REQ-025 Latency: instruction at pc fetched in cycle N SHALL appear with dec_valid = 1 in cycle N+1; after a redirect in cycle N the target instruction SHALL appear in cycle N+2.
REQ-026 With dec_ready held 1 and no redirect, throughput SHALL be one instruction per cycle.

Reset
REQ-027 While rst = 1 at a clock edge: pc <- RESET_PC, count <- 0, FIFO pointers <- 0, misalign <- 0; rst SHALL override redirect and push.
REQ-028 After reset: dec_valid = 0, dec_inst = 0, dec_pc = 0; first push at the first edge with rst = 0.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries without a pop.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN: when defined, a redirect with redirect_target[1:0] != 0 SHALL load pc with {redirect_target[31:2], 2'b00} and set misalign to 1, sticky until reset.
REQ-031 When FETCH_MISALIGN_CHECK_EN is undefined, redirect_target SHALL load unmodified and misalign SHALL be constant 0.

Verification
REQ-032 Reset then 4 cycles with dec_ready = 1 -> dec_pc sequence 0x0, 0x4, 0x8 starting cycle 1 after reset release, dec_valid = 1 continuously.
REQ-033 dec_ready = 0 for 5 cycles, DEPTH = 2 -> count saturates at 2, pc stops at 0x8, no entry lost; release -> dec_pc 0x0, 0x4, 0x8 in order.
REQ-034 Redirect to 0x100 while buffer full -> dec_valid = 0 next cycle, dec_pc = 0x100 two cycles after redirect, old entries never presented.
REQ-035 pc = 0xFFFF_FFFC, dec_ready = 1 -> next dec_pc 0xFFFF_FFFC then 0x0000_0000.
REQ-036 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> dec_pc = 0x100, misalign = 1 held until rst; without macro -> dec_pc = 0x102, misalign = 0.
REQ-037 Assert rst with 2 buffered entries and redirect_valid = 1 -> next cycle pc = RESET_PC, dec_valid = 0, misalign = 0.
